alu_arbiter: RTL and testbench

- Shares one combinational `alu` instance (DATA_WIDTH-wide, 3-bit opcode) between two requesters.
- Per-requester valid/ready request handshake; fair 2-way round-robin grant.
- Registers operands into the ALU, captures the ALU result, returns it on one response channel tagged with the requester id.
- Sits between two datapath masters (e.g. CPU execute stage and DMA/helper unit) and the single shared `alu`.

---
 rtl/alu_defs_pkg.sv | 22 ++
 rtl/rr_arbiter2.sv | 22 ++
 rtl/alu_arbiter.sv | 120 ++++++++++++
 tb/tb_alu_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_defs_pkg.sv
// Shared definitions for the ALU arbiter slice: ALU opcode encodings,
// the arbiter FSM state type and the default datapath width.
package alu_defs;

  localparam int DEFAULT_DATA_WIDTH = 16;

  localparam logic [2:0] OC_ADD = 3'd0;
  localparam logic [2:0] OC_SUB = 3'd1;
  localparam logic [2:0] OC_MUL = 3'd2;
  localparam logic [2:0] OC_DIV = 3'd3;
  localparam logic [2:0] OC_NOT = 3'd4;
  localparam logic [2:0] OC_XOR = 3'd5;
  localparam logic [2:0] OC_OR  = 3'd6;
  localparam logic [2:0] OC_AND = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone valid requester wins outright, and on a
// tie the requester that did not win last time is chosen.
module rr_arbiter2 (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_lastGrant,
  output logic o_grantValid,
  output logic o_grant
);

  // o_grant is the winning requester index; only meaningful with o_grantValid.
  always_comb begin
    o_grantValid = i_valid0 | i_valid1;
    o_grant      = 1'b0;
    if (i_valid0 && i_valid1) begin
      o_grant = ~i_lastGrant;
    end else if (i_valid1) begin
      o_grant = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational alu between two requesters (IDLE -> EXEC -> RESP).
// Optional build macro ALU_ARB_DIVZERO_EN flags divide-by-zero on rsp_err.
module alu_arbiter
  import alu_defs::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [2:0]            req0_oc,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [2:0]            req1_oc,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  output logic [2:0]            alu_oc,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_f,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err
);

  state_t                r_state;
  logic                  r_lastGrant;
  logic                  r_id;
  logic                  w_gntValid;
  logic                  w_gnt;
  logic                  w_take;
  logic [2:0]            w_selOc;
  logic [DATA_WIDTH-1:0] w_selA;
  logic [DATA_WIDTH-1:0] w_selB;

`ifdef ALU_ARB_DIVZERO_EN
  logic r_divZero;
  logic r_rspErr;
  assign rsp_err = r_rspErr;
`else
  assign rsp_err = 1'b0;
`endif

  rr_arbiter2 u_rr (
    .i_valid0    (req0_valid),
    .i_valid1    (req1_valid),
    .i_lastGrant (r_lastGrant),
    .o_grantValid(w_gntValid),
    .o_grant     (w_gnt)
  );

  // Ready is gated by rst so no requester sees an acceptance during reset.
  assign w_take     = (r_state == ST_IDLE) && !rst && w_gntValid;
  assign req0_ready = w_take && !w_gnt;
  assign req1_ready = w_take &&  w_gnt;

  assign w_selOc = w_gnt ? req1_oc : req0_oc;
  assign w_selA  = w_gnt ? req1_a  : req0_a;
  assign w_selB  = w_gnt ? req1_b  : req0_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_lastGrant <= 1'b1;
      r_id        <= 1'b0;
      alu_oc      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_data    <= '0;
`ifdef ALU_ARB_DIVZERO_EN
      r_divZero   <= 1'b0;
      r_rspErr    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            alu_oc      <= w_selOc;
            alu_a       <= w_selA;
            alu_b       <= w_selB;
            r_id        <= w_gnt;
            r_lastGrant <= w_gnt;
            r_state     <= ST_EXEC;
`ifdef ALU_ARB_DIVZERO_EN
            r_divZero   <= (w_selOc == OC_DIV) && (w_selB == '0);
`endif
          end
        end
        // The alu still sees the operands on a divide-by-zero; only the
        // captured result is overridden.
        ST_EXEC: begin
`ifdef ALU_ARB_DIVZERO_EN
          rsp_data <= r_divZero ? '1 : alu_f;
          r_rspErr <= r_divZero;
`else
          rsp_data <= alu_f;
`endif
          rsp_id    <= r_id;
          rsp_valid <= 1'b1;
          r_state   <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural alu model.
module tb_alu_arbiter;

  localparam logic [2:0] ADD = 3'd0;
  localparam logic [2:0] SUB = 3'd1;
  localparam logic [2:0] MUL = 3'd2;
  localparam logic [2:0] DIV = 3'd3;
  localparam logic [2:0] XOR = 3'd5;

`ifdef ALU_ARB_DIVZERO_EN
  localparam logic [15:0] EXP_DZ_DATA = 16'hFFFF;
  localparam logic        EXP_DZ_ERR  = 1'b1;
`else
  localparam logic [15:0] EXP_DZ_DATA = 16'h0000;
  localparam logic        EXP_DZ_ERR  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_oc = '0, req1_oc = '0;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]  alu_oc;
  logic [15:0] alu_a, alu_b, alu_f;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Stand-in for the shared alu; divide by zero returns zero here.
  always_comb begin
    case (alu_oc)
      3'd0: alu_f = alu_a + alu_b;
      3'd1: alu_f = alu_a - alu_b;
      3'd2: alu_f = alu_a * alu_b;
      3'd3: alu_f = (alu_b == 16'd0) ? 16'd0 : alu_a / alu_b;
      3'd4: alu_f = ~alu_a;
      3'd5: alu_f = alu_a ^ alu_b;
      3'd6: alu_f = alu_a | alu_b;
      default: alu_f = alu_a & alu_b;
    endcase
  end

  alu_arbiter #(.DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_oc(req0_oc),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_oc(req1_oc),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_oc(alu_oc), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Issues one op on requester `who` and returns the captured response.
  task automatic do_op(input bit who, input logic [2:0] oc, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] d, output logic id, output logic e, output bit to);
    int n;
    to = 1'b0; d = '0; id = 1'b0; e = 1'b0;
    rsp_ready = 1'b1;
    if (!who) begin req0_oc = oc; req0_a = a; req0_b = b; req0_valid = 1'b1; end
    else      begin req1_oc = oc; req1_a = a; req1_b = b; req1_valid = 1'b1; end
    #1;
    n = 0;
    while (!(who ? req1_ready : req0_ready) && n < 10) begin tick(); #1; n++; end
    if (n >= 10) begin to = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; return; end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    n = 0;
    while (!rsp_valid && n < 10) begin tick(); #1; n++; end
    if (n >= 10) begin to = 1'b1; return; end
    d = rsp_data; id = rsp_id; e = rsp_err;
    tick();
  endtask

  task automatic test_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1 rst = 1'b1;
    #2;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_valid got=%0h exp=0", rsp_valid); end
    total++; if (rsp_id !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_id got=%0h exp=0", rsp_id); end
    total++; if (rsp_data !== 16'h0) begin bad++; $display("[TB] FAIL reset_rsp_data got=%0h exp=0", rsp_data); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_err got=%0h exp=0", rsp_err); end
    total++; if ({alu_oc, alu_a, alu_b} !== 35'h0) begin bad++; $display("[TB] FAIL reset_alu_regs got=%0h exp=0", {alu_oc, alu_a, alu_b}); end
    total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("[TB] FAIL reset_ready got=%0b exp=00", {req0_ready, req1_ready}); end
    tick();
    rst = 1'b0;
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("[TB] FAIL reset_first_tie got=%0b exp=10", {req0_ready, req1_ready}); end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_single();
    apply_reset();
    req0_oc = ADD; req0_a = 16'd5; req0_b = 16'd3; req0_valid = 1'b1;
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("[TB] FAIL single_ready got=%0b exp=10", {req0_ready, req1_ready}); end
    tick(); #1;
    total++; if (req0_ready !== 1'b0) begin bad++; $display("[TB] FAIL single_exec_ready got=%0h exp=0", req0_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_exec_rsp_valid got=%0h exp=0", rsp_valid); end
    total++; if ({alu_a, alu_b} !== {16'd5, 16'd3}) begin bad++; $display("[TB] FAIL single_alu_operands got=%0h exp=%0h", {alu_a, alu_b}, {16'd5, 16'd3}); end
    tick();
    req0_valid = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_rsp_valid got=%0h exp=1", rsp_valid); end
    total++; if (rsp_data !== 16'd8) begin bad++; $display("[TB] FAIL single_rsp_data got=%0h exp=8", rsp_data); end
    total++; if (rsp_id !== 1'b0) begin bad++; $display("[TB] FAIL single_rsp_id got=%0h exp=0", rsp_id); end
    tick(); #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_rsp_consumed got=%0h exp=0", rsp_valid); end
  endtask

  task automatic test_simultaneous();
    int gCount = 0, rCount = 0;
    bit both = 0, drop0 = 0, drop1 = 0;
    logic gnt [2];
    logic rid [2];
    logic [15:0] rd [2];
    gnt[0] = 1'bx; gnt[1] = 1'bx; rid[0] = 1'bx; rid[1] = 1'bx; rd[0] = 'x; rd[1] = 'x;
    apply_reset();
    req0_oc = SUB; req0_a = 16'd10; req0_b = 16'd4; req0_valid = 1'b1;
    req1_oc = MUL; req1_a = 16'd6;  req1_b = 16'd7; req1_valid = 1'b1;
    for (int c = 0; c < 20 && rCount < 2; c++) begin
      #1;
      if (req0_ready && req1_ready) both = 1;
      if (req0_ready && gCount < 2) begin gnt[gCount] = 1'b0; gCount++; drop0 = 1; end
      if (req1_ready && gCount < 2) begin gnt[gCount] = 1'b1; gCount++; drop1 = 1; end
      if (rsp_valid && rCount < 2) begin rid[rCount] = rsp_id; rd[rCount] = rsp_data; rCount++; end
      tick();
      if (drop0) begin req0_valid = 1'b0; drop0 = 0; end
      if (drop1) begin req1_valid = 1'b0; drop1 = 0; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    total++; if (both !== 1'b0) begin bad++; $display("[TB] FAIL sim_both_ready got=%0h exp=0", both); end
    total++; if (rCount != 2) begin bad++; $display("[TB] FAIL sim_rsp_count got=%0d exp=2", rCount); end
    total++; if ({gnt[0], gnt[1]} !== 2'b01) begin bad++; $display("[TB] FAIL sim_grant_order got=%0b exp=01", {gnt[0], gnt[1]}); end
    total++; if ({rid[0], rd[0]} !== {1'b0, 16'd6}) begin bad++; $display("[TB] FAIL sim_rsp0 got=%0h exp=%0h", {rid[0], rd[0]}, {1'b0, 16'd6}); end
    total++; if ({rid[1], rd[1]} !== {1'b1, 16'd42}) begin bad++; $display("[TB] FAIL sim_rsp1 got=%0h exp=%0h", {rid[1], rd[1]}, {1'b1, 16'd42}); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    rsp_ready = 1'b0;
    req0_oc = ADD; req0_a = 16'd1; req0_b = 16'd1; req0_valid = 1'b1;
    req1_oc = XOR; req1_a = 16'h00F0; req1_b = 16'h0FF0; req1_valid = 1'b1;
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("[TB] FAIL bp_grant got=%0b exp=10", {req0_ready, req1_ready}); end
    tick();
    req0_valid = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if ({rsp_valid, rsp_data} !== {1'b1, 16'd2}) begin bad++; $display("[TB] FAIL bp_hold_rsp cycle=%0d got=%0h exp=%0h", c, {rsp_valid, rsp_data}, {1'b1, 16'd2}); end
      total++; if (req1_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_req1_ready cycle=%0d got=%0h exp=0", c, req1_ready); end
      tick();
    end
    rsp_ready = 1'b1;
    tick(); #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_release_valid got=%0h exp=0", rsp_valid); end
    total++; if (req1_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_idle_next got=%0h exp=1", req1_ready); end
    req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [5:0] seq;
    logic [5:0] expSeq;
    int gCount = 0;
    expSeq = 6'b101010;
    seq = '0;
    apply_reset();
    req0_oc = ADD; req0_a = 16'd2; req0_b = 16'd2; req0_valid = 1'b1;
    req1_oc = SUB; req1_a = 16'd9; req1_b = 16'd1; req1_valid = 1'b1;
    for (int c = 0; c < 40 && gCount < 6; c++) begin
      #1;
      if (req0_ready) begin seq[gCount] = 1'b0; gCount++; end
      else if (req1_ready) begin seq[gCount] = 1'b1; gCount++; end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    total++; if (gCount != 6) begin bad++; $display("[TB] FAIL rr_grant_count got=%0d exp=6", gCount); end
    total++; if (seq !== expSeq) begin bad++; $display("[TB] FAIL rr_sequence got=%06b exp=%06b (bit0 first)", seq, expSeq); end
  endtask

  task automatic test_reset_in_resp();
    apply_reset();
    rsp_ready = 1'b0;
    req0_oc = ADD; req0_a = 16'd5; req0_b = 16'd3; req0_valid = 1'b1;
    #1;
    tick();
    req0_valid = 1'b0;
    tick(); #1;
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL rir_pre_valid got=%0h exp=1", rsp_valid); end
    rst = 1'b1;
    #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rir_async_valid got=%0h exp=0", rsp_valid); end
    total++; if ({alu_oc, alu_a, alu_b} !== 35'h0) begin bad++; $display("[TB] FAIL rir_alu_regs got=%0h exp=0", {alu_oc, alu_a, alu_b}); end
    total++; if (rsp_data !== 16'h0) begin bad++; $display("[TB] FAIL rir_rsp_data got=%0h exp=0", rsp_data); end
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("[TB] FAIL rir_next_grant got=%0b exp=10", {req0_ready, req1_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_divide();
    logic [15:0] d;
    logic id, e;
    bit to;
    apply_reset();
    do_op(1'b0, DIV, 16'd9, 16'd0, d, id, e, to);
    total++; if (to !== 1'b0) begin bad++; $display("[TB] FAIL div0_timeout got=%0h exp=0", to); end
    total++; if (d !== EXP_DZ_DATA) begin bad++; $display("[TB] FAIL div0_data got=%0h exp=%0h", d, EXP_DZ_DATA); end
    total++; if (e !== EXP_DZ_ERR) begin bad++; $display("[TB] FAIL div0_err got=%0h exp=%0h", e, EXP_DZ_ERR); end
    do_op(1'b1, DIV, 16'd9, 16'd3, d, id, e, to);
    total++; if (to !== 1'b0) begin bad++; $display("[TB] FAIL div3_timeout got=%0h exp=0", to); end
    total++; if ({id, d} !== {1'b1, 16'd3}) begin bad++; $display("[TB] FAIL div3_data got=%0h exp=%0h", {id, d}, {1'b1, 16'd3}); end
    total++; if (e !== 1'b0) begin bad++; $display("[TB] FAIL div3_err got=%0h exp=0", e); end
    do_op(1'b0, MUL, 16'h0100, 16'h0101, d, id, e, to);
    total++; if ({to, id, d} !== {1'b0, 1'b0, 16'h0100}) begin bad++; $display("[TB] FAIL mul_wrap got=%0h exp=%0h", {to, id, d}, {1'b0, 1'b0, 16'h0100}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_round_robin();
    test_reset_in_resp();
    test_divide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
